// File: rtl/sc_circuit.sv
// Stochastic-computing slice: LFSR next-state logic, comparator SNG and a
// two-tap delay-line function. The harness holds all of the state.
module sc_circuit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] input_s,
    input  logic [7:0] input_b,
    input  logic       in_x_1,
    input  logic       in_x_2,
    output logic [7:0] output_s,
    output logic       output_circuit,
    output logic       out_x_1,
    output logic       out_x_2
);

    logic fb;
    logic x;
    logic unused_ok;

    // clk and rst_n only keep the port list uniform across generated
    // circuits; folding them into a dead signal documents that.
    assign unused_ok = &{1'b0, clk, rst_n};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        fb             = 1'b0;
        x              = 1'b0;
        output_s       = 8'h01;
        output_circuit = 1'b0;
        out_x_1        = 1'b0;
        out_x_2        = 1'b0;

        // x^8+x^6+x^5+x^4+1; the all-zero state is forced back into the cycle.
        fb = input_s[7] ^ input_s[5] ^ input_s[4] ^ input_s[3];
        if (input_s != 8'h00) begin
            output_s = {input_s[6:0], fb};
        end

        x              = (input_b > input_s);
        out_x_1        = x;
        out_x_2        = in_x_1;
        output_circuit = x & in_x_1 & ~in_x_2;
    end

endmodule

// File: tb/tb_sc_circuit.sv
// Directed bench for sc_circuit: combinational vectors plus a harness loop
// that registers the loop-back ports once per clock period.
module tb_sc_circuit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] input_s;
    logic [7:0] input_b;
    logic       in_x_1;
    logic       in_x_2;
    logic [7:0] output_s;
    logic       output_circuit;
    logic       out_x_1;
    logic       out_x_2;

    int tests = 0;
    int fails = 0;

    localparam int NWIN = 7;
    logic [7:0]   sweep_b [NWIN] = '{8'd0, 8'd32, 8'd64, 8'd128, 8'd192, 8'd224, 8'd255};
    logic [254:0] stream_lo [NWIN];
    logic [254:0] stream_hi [NWIN];

    always #10 clk = ~clk;

    sc_circuit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .input_s        (input_s),
        .input_b        (input_b),
        .in_x_1         (in_x_1),
        .in_x_2         (in_x_2),
        .output_s       (output_s),
        .output_circuit (output_circuit),
        .out_x_1        (out_x_1),
        .out_x_2        (out_x_2)
    );

    // Drive away from the rising edge and let the combinational outputs settle.
    task automatic apply(input logic [7:0] s, input logic [7:0] b,
                         input logic x1, input logic x2);
        @(negedge clk);
        input_s = s;
        input_b = b;
        in_x_1  = x1;
        in_x_2  = x2;
        #1;
    endtask

    task automatic expect_vec(input string name, input logic [7:0] exp_s,
                              input logic exp_c, input logic exp_x1, input logic exp_x2);
        tests++;
        if (output_s !== exp_s || output_circuit !== exp_c ||
            out_x_1 !== exp_x1 || out_x_2 !== exp_x2) begin
            fails++;
            $display("FAIL %s: got s=%h c=%b x1=%b x2=%b, want s=%h c=%b x1=%b x2=%b",
                     name, output_s, output_circuit, out_x_1, out_x_2,
                     exp_s, exp_c, exp_x1, exp_x2);
        end
    endtask

    // One full LFSR period from seed 01 with the delay chain cleared.
    task automatic run_window(input logic [7:0] b, input logic rst_val,
                              output int ones, output int xs, output logic [254:0] stream);
        logic [7:0] s;
        logic       x1;
        logic       x2;
        s      = 8'h01;
        x1     = 1'b0;
        x2     = 1'b0;
        ones   = 0;
        xs     = 0;
        stream = '0;
        rst_n  = rst_val;
        for (int i = 0; i < 255; i++) begin
            apply(s, b, x1, x2);
            stream[i] = output_circuit;
            if (output_circuit === 1'b1) ones++;
            if (out_x_1 === 1'b1) xs++;
            s  = output_s;
            x2 = out_x_2;
            x1 = out_x_1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        apply(8'h40, 8'd128, 1'b1, 1'b0);
        expect_vec("reset_low_static", 8'h80, 1'b1, 1'b1, 1'b1);
        apply(8'h00, 8'd0, 1'b0, 1'b0);
        expect_vec("reset_low_zero", 8'h01, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_lfsr_step;
        apply(8'h01, 8'd0, 1'b0, 1'b0);
        expect_vec("lfsr_01", 8'h02, 1'b0, 1'b0, 1'b0);
        apply(8'h08, 8'd0, 1'b0, 1'b0);
        expect_vec("lfsr_08", 8'h11, 1'b0, 1'b0, 1'b0);
        apply(8'h00, 8'd0, 1'b0, 1'b0);
        expect_vec("lfsr_lockup", 8'h01, 1'b0, 1'b0, 1'b0);
        apply(8'h80, 8'd0, 1'b0, 1'b0);
        expect_vec("lfsr_80", 8'h01, 1'b0, 1'b0, 1'b0);
        apply(8'hFF, 8'd0, 1'b0, 1'b0);
        expect_vec("lfsr_ff", 8'hFE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lfsr_period;
        logic [255:0] seen;
        logic [7:0]   s;
        int           distinct;
        int           early;
        seen     = '0;
        s        = 8'h01;
        distinct = 0;
        early    = 0;
        for (int i = 0; i < 255; i++) begin
            if (s == 8'h00 || seen[s]) early++;
            else distinct++;
            seen[s] = 1'b1;
            apply(s, 8'd0, 1'b0, 1'b0);
            s = output_s;
            if (s == 8'h01 && i != 254) early++;
        end
        tests++;
        if (distinct != 255 || early != 0) begin
            fails++;
            $display("FAIL lfsr_period_distinct: got %0d distinct, %0d repeats, want 255 and 0",
                     distinct, early);
        end
        tests++;
        if (s !== 8'h01) begin
            fails++;
            $display("FAIL lfsr_period_return: got %h, want 01", s);
        end
    endtask

    task automatic test_static;
        apply(8'h40, 8'd128, 1'b1, 1'b0);
        expect_vec("static_b128_s40", 8'h80, 1'b1, 1'b1, 1'b1);
        apply(8'hC0, 8'd128, 1'b1, 1'b0);
        expect_vec("static_b128_sc0", 8'h81, 1'b0, 1'b0, 1'b1);
        apply(8'h40, 8'd128, 1'b1, 1'b1);
        expect_vec("static_x2_blocks", 8'h80, 1'b0, 1'b1, 1'b1);
        apply(8'h40, 8'd128, 1'b0, 1'b0);
        expect_vec("static_x1_blocks", 8'h80, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_compare_edges;
        apply(8'h05, 8'd5, 1'b1, 1'b0);
        expect_vec("cmp_equal", 8'h0A, 1'b0, 1'b0, 1'b1);
        apply(8'h05, 8'd6, 1'b1, 1'b0);
        expect_vec("cmp_above", 8'h0A, 1'b1, 1'b1, 1'b1);
        apply(8'hFF, 8'd255, 1'b1, 1'b0);
        expect_vec("cmp_b255_sff", 8'hFE, 1'b0, 1'b0, 1'b1);
        apply(8'hFE, 8'd255, 1'b1, 1'b0);
        expect_vec("cmp_b255_sfe", 8'hFC, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_zero_operand;
        int           ones;
        int           xs;
        logic [254:0] st;
        run_window(8'd0, 1'b1, ones, xs, st);
        tests++;
        if (ones != 0 || xs != 0) begin
            fails++;
            $display("FAIL zero_operand: got %0d ones, %0d x, want 0 and 0", ones, xs);
        end
    endtask

    task automatic test_full_operand;
        int           ones;
        int           xs;
        logic [254:0] st;
        run_window(8'd255, 1'b1, ones, xs, st);
        tests++;
        if (xs != 254) begin
            fails++;
            $display("FAIL full_operand_x: got %0d, want 254", xs);
        end
        // Cycle 1 always fires after warm-up; the single x=0 at state FF can add one more.
        tests++;
        if (ones < 1 || ones > 2) begin
            fails++;
            $display("FAIL full_operand_ones: got %0d, want 1..2", ones);
        end
    endtask

    task automatic test_sweep(input logic rst_val);
        int           ones;
        int           xs;
        logic [254:0] st;
        real          p;
        real          expv;
        for (int w = 0; w < NWIN; w++) begin
            run_window(sweep_b[w], rst_val, ones, xs, st);
            if (rst_val) stream_hi[w] = st;
            else         stream_lo[w] = st;
            p    = real'(sweep_b[w]) / 256.0;
            expv = 255.0 * p * p * (1.0 - p);
            tests++;
            if (real'(ones) > expv + 12.0 || real'(ones) < expv - 12.0) begin
                fails++;
                $display("FAIL sweep_b%0d_rst%0b: got %0d ones, want %0.1f +/-12",
                         sweep_b[w], rst_val, ones, expv);
            end
        end
    endtask

    task automatic test_reset_independence;
        for (int w = 0; w < NWIN; w++) begin
            tests++;
            if (stream_lo[w] !== stream_hi[w]) begin
                fails++;
                $display("FAIL reset_indep_b%0d: streams differ, rst0=%h rst1=%h",
                         sweep_b[w], stream_lo[w], stream_hi[w]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        input_s = 8'h01;
        input_b = 8'd0;
        in_x_1  = 1'b0;
        in_x_2  = 1'b0;
        test_reset;
        test_lfsr_step;
        test_lfsr_period;
        test_static;
        test_compare_edges;
        test_zero_operand;
        test_full_operand;
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_reset_independence;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
